vc_fifo_buffer: RTL and testbench

VC_FIFO_BUFFER -- requirements
Module: vc_fifo_buffer

---
 rtl/noc_pkg.sv | 24 ++
 rtl/vc_fifo_slice.sv | 53 +++++
 rtl/vc_fifo_buffer.sv | 86 ++++++++
 tb/tb_vc_fifo_buffer.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: width helper, VC index width and flit-type encoding.
package noc_pkg;

  // Ceiling log2 usable in parameter expressions; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  localparam int unsigned NUM_VC_DEFAULT = 4;
  localparam int unsigned VC_IDX_W       = clog2(NUM_VC_DEFAULT);

  typedef enum logic [1:0] {
    FlitHead   = 2'b00,
    FlitBody   = 2'b01,
    FlitTail   = 2'b10,
    FlitSingle = 2'b11
  } flit_type_e;

endpackage

// File: rtl/vc_fifo_slice.sv
// One virtual-channel FIFO: register storage, wrapping pointers and occupancy counter.
// Callers pass already-qualified write/read strobes; no overflow protection here.
module vc_fifo_slice
  import noc_pkg::*;
#(
  parameter int unsigned NUM_BITS = 8,
  parameter int unsigned DEPTH    = 8,
  localparam int unsigned PW      = clog2(DEPTH),
  localparam int unsigned CW      = clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [NUM_BITS-1:0] wr_data,
  input  logic                rd_en,
  output logic [NUM_BITS-1:0] rd_data,
  output logic [CW-1:0]       count,
  output logic                empty,
  output logic                full
);

  logic [NUM_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]       count_q;

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));

endmodule

// File: rtl/vc_fifo_buffer.sv
// Multi-VC input buffer: write demux, read mux, registered read data, credit pulses
// and sticky overflow/underflow flags around NUM_VC independent FIFO slices.
module vc_fifo_buffer
  import noc_pkg::*;
#(
  parameter int unsigned NUM_BITS = 8,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned NUM_VC   = 4,
  localparam int unsigned VCW     = clog2(NUM_VC),
  localparam int unsigned CW      = clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [VCW-1:0]       wr_vc,
  input  logic [NUM_BITS-1:0]  fifo_in,
  input  logic                 rd_en,
  input  logic [VCW-1:0]       rd_vc,
  output logic [NUM_BITS-1:0]  fifo_out,
  output logic                 rd_valid,
  output logic [NUM_VC-1:0]    empty,
  output logic [NUM_VC-1:0]    full,
  output logic [NUM_VC-1:0]    credit_out,
  output logic [NUM_VC*CW-1:0] fifo_counter,
  output logic                 err_ovf,
  output logic                 err_udf
);

  logic [NUM_BITS-1:0] head [NUM_VC];
  logic [NUM_VC-1:0]   slice_wr, slice_rd;
  logic                wr_vc_ok, rd_vc_ok;
  logic                wr_ok, rd_ok;

  // Out-of-range VC indices are treated as full/empty so they are never accepted.
  assign wr_vc_ok = (32'(wr_vc) < NUM_VC);
  assign rd_vc_ok = (32'(rd_vc) < NUM_VC);

  // Acceptance uses the pre-edge flags, so a same-cycle read never frees a slot for a write.
  assign wr_ok = wr_en && wr_vc_ok && !full[wr_vc];
  assign rd_ok = rd_en && rd_vc_ok && !empty[rd_vc];

  // Decode qualified strobes onto the targeted slice.
  always_comb begin
    slice_wr = '0;
    slice_rd = '0;
    for (int unsigned v = 0; v < NUM_VC; v++) begin
      slice_wr[v] = wr_ok && (wr_vc == VCW'(v));
      slice_rd[v] = rd_ok && (rd_vc == VCW'(v));
    end
  end

  for (genvar v = 0; v < NUM_VC; v++) begin : g_slice
    vc_fifo_slice #(
      .NUM_BITS (NUM_BITS),
      .DEPTH    (DEPTH)
    ) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (slice_wr[v]),
      .wr_data (fifo_in),
      .rd_en   (slice_rd[v]),
      .rd_data (head[v]),
      .count   (fifo_counter[v*CW +: CW]),
      .empty   (empty[v]),
      .full    (full[v])
    );
  end

  // Output registers and sticky error flags; fifo_out holds when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_out   <= '0;
      rd_valid   <= 1'b0;
      credit_out <= '0;
      err_ovf    <= 1'b0;
      err_udf    <= 1'b0;
    end else begin
      rd_valid   <= rd_ok;
      credit_out <= slice_rd;
      if (rd_ok) fifo_out <= head[rd_vc];
      if (wr_en && !wr_ok) err_ovf <= 1'b1;
      if (rd_en && !rd_ok) err_udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vc_fifo_buffer.sv
// Directed bench for vc_fifo_buffer with NUM_BITS=8, DEPTH=4, NUM_VC=2.
module tb_vc_fifo_buffer;

  localparam int unsigned NB = 8;
  localparam int unsigned DP = 4;
  localparam int unsigned NV = 2;
  localparam int unsigned CWT = 3;

  logic            clk, rst_n;
  logic            wr_en, rd_en;
  logic [0:0]      wr_vc, rd_vc;
  logic [NB-1:0]   fifo_in, fifo_out;
  logic            rd_valid, err_ovf, err_udf;
  logic [NV-1:0]   empty, full, credit_out;
  logic [NV*CWT-1:0] fifo_counter;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  vc_fifo_buffer #(
    .NUM_BITS (NB),
    .DEPTH    (DP),
    .NUM_VC   (NV)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_vc        (wr_vc),
    .fifo_in      (fifo_in),
    .rd_en        (rd_en),
    .rd_vc        (rd_vc),
    .fifo_out     (fifo_out),
    .rd_valid     (rd_valid),
    .empty        (empty),
    .full         (full),
    .credit_out   (credit_out),
    .fifo_counter (fifo_counter),
    .err_ovf      (err_ovf),
    .err_udf      (err_udf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  // Drive one clock of stimulus, then sample 1 ns after the edge.
  task automatic cycle(input logic we, input logic wvc, input logic [7:0] d,
                       input logic re, input logic rvc);
    wr_en = we; wr_vc = wvc; fifo_in = d; rd_en = re; rd_vc = rvc;
    @(posedge clk);
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic wr(input logic vc, input logic [7:0] d);
    cycle(1'b1, vc, d, 1'b0, 1'b0);
  endtask

  task automatic rd_check(input logic vc, input logic [7:0] exp, input string tag);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, vc);
    check(tag, 32'(fifo_out), 32'(exp));
    check({tag, "_valid"}, 32'(rd_valid), 32'd1);
    check({tag, "_credit"}, 32'(credit_out), (vc ? 32'd2 : 32'd1));
  endtask

  initial begin
    wr_en = 0; rd_en = 0; wr_vc = 0; rd_vc = 0; fifo_in = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;

    // Reset state
    check("rst_empty", 32'(empty), 32'h3);
    check("rst_full", 32'(full), 32'h0);
    check("rst_count", 32'(fifo_counter), 32'h0);
    check("rst_out", 32'(fifo_out), 32'h0);
    check("rst_valid", 32'(rd_valid), 32'h0);
    check("rst_errs", {30'd0, err_ovf, err_udf}, 32'h0);

    // Basic write/read on VC0
    wr(1'b0, 8'h11);
    wr(1'b0, 8'h22);
    check("basic_count", 32'(fifo_counter), 32'h2);
    rd_check(1'b0, 8'h11, "basic_rd0");
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check("idle_valid", 32'(rd_valid), 32'h0);
    check("idle_credit", 32'(credit_out), 32'h0);
    check("idle_hold", 32'(fifo_out), 32'h11);
    rd_check(1'b0, 8'h22, "basic_rd1");
    check("basic_empty", 32'(empty), 32'h3);

    // Overflow on VC1
    wr(1'b1, 8'hA1); wr(1'b1, 8'hA2); wr(1'b1, 8'hA3);
    check("ovf_notfull", 32'(full), 32'h0);
    wr(1'b1, 8'hA4);
    check("ovf_full", 32'(full), 32'h2);
    check("ovf_count", 32'(fifo_counter), 32'h20);
    wr(1'b1, 8'hA5);
    check("ovf_err", 32'(err_ovf), 32'h1);
    check("ovf_count_hold", 32'(fifo_counter), 32'h20);
    rd_check(1'b1, 8'hA1, "ovf_rd0");
    rd_check(1'b1, 8'hA2, "ovf_rd1");
    rd_check(1'b1, 8'hA3, "ovf_rd2");
    rd_check(1'b1, 8'hA4, "ovf_rd3");
    check("ovf_empty", 32'(empty), 32'h3);

    // Write to full VC0 with simultaneous read: write dropped
    wr(1'b0, 8'hB1); wr(1'b0, 8'hB2); wr(1'b0, 8'hB3); wr(1'b0, 8'hB4);
    cycle(1'b1, 1'b0, 8'hB5, 1'b1, 1'b0);
    check("fullrw_out", 32'(fifo_out), 32'hB1);
    check("fullrw_count", 32'(fifo_counter), 32'h3);
    rd_check(1'b0, 8'hB2, "fullrw_rd1");
    rd_check(1'b0, 8'hB3, "fullrw_rd2");
    rd_check(1'b0, 8'hB4, "fullrw_rd3");
    check("fullrw_empty", 32'(empty), 32'h3);

    // Simultaneous write/read same VC and different VCs
    wr(1'b0, 8'hC1); wr(1'b0, 8'hC2);
    cycle(1'b1, 1'b0, 8'hC3, 1'b1, 1'b0);
    check("same_out", 32'(fifo_out), 32'hC1);
    check("same_count", 32'(fifo_counter), 32'h2);
    cycle(1'b1, 1'b1, 8'hD1, 1'b1, 1'b0);
    check("diff_out", 32'(fifo_out), 32'hC2);
    check("diff_count", 32'(fifo_counter), 32'h9);
    rd_check(1'b0, 8'hC3, "diff_rd0");
    rd_check(1'b1, 8'hD1, "diff_rd1");

    // Underflow on empty VC1
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    check("udf_valid", 32'(rd_valid), 32'h0);
    check("udf_err", 32'(err_udf), 32'h1);
    check("udf_hold", 32'(fifo_out), 32'hD1);
    check("udf_credit", 32'(credit_out), 32'h0);

    // Pointer wrap on VC1
    for (int i = 0; i < 10; i++) begin
      wr(1'b1, 8'(8'h30 + i));
      rd_check(1'b1, 8'(8'h30 + i), "wrap");
    end
    check("wrap_count", 32'(fifo_counter), 32'h0);

    // Mid-operation asynchronous reset
    wr(1'b0, 8'hE1); wr(1'b0, 8'hE2); wr(1'b0, 8'hE3);
    check("prerst_count", 32'(fifo_counter), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", 32'(fifo_counter), 32'h0);
    check("arst_empty", 32'(empty), 32'h3);
    check("arst_errs", {30'd0, err_ovf, err_udf}, 32'h0);
    check("arst_out", 32'(fifo_out), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    wr(1'b0, 8'hAA);
    rd_check(1'b0, 8'hAA, "postrst_rd");
    check("postrst_empty", 32'(empty), 32'h3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
